// File: rtl/capture_pkg.sv
// Shared definitions for the camera capture front-end:
// FSM state encoding and default capture geometry.
package capture_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

    localparam int unsigned DEF_BUF_STRIDE = 32'h0002_5800;
    localparam int          DEF_ROWS       = 480;

    // Row counter width; the count saturates at its all-ones value.
    localparam int               ROW_W   = 10;
    localparam logic [ROW_W-1:0] ROW_MAX = '1;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into DATA_W-bit words, lowest lane first, and flags
// the cycle in which the top lane arrives so the caller can latch the word.
module byte_packer #(
    parameter int DATA_W = 128
) (
    input  logic              p_clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_en,
    input  logic [7:0]        data,
    output logic [DATA_W-1:0] word,
    output logic              word_done
);
    localparam int                BPW       = DATA_W / 8;
    localparam int                LANE_W    = $clog2(BPW);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BPW - 1);

    logic [LANE_W-1:0] lane_q;
    logic [DATA_W-9:0] lanes_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            lanes_q <= '0;
        end else if (clear) begin
            lane_q <= '0;
        end else if (byte_en) begin
            if (lane_q == LAST_LANE) begin
                lane_q <= '0;
            end else begin
                lanes_q[int'(lane_q)*8 +: 8] <= data;
                lane_q                       <= lane_q + LANE_W'(1);
            end
        end
    end

    // The top lane is never stored: it is taken straight from the input.
    assign word      = {data, lanes_q};
    assign word_done = byte_en && (lane_q == LAST_LANE);

endmodule

// File: rtl/frame_capture_ring.sv
// Camera capture front-end: packs pixel bytes into words, writes them into a
// ring of DDR frame buffers, rejects bad frames and drives an HDR bracket.
module frame_capture_ring
    import capture_pkg::*;
#(
    parameter int                DATA_W     = 128,
    parameter int                ADDR_W     = 25,
    parameter int                NUM_BUFS   = 6,
    parameter logic [ADDR_W-1:0] BUF_STRIDE = ADDR_W'(DEF_BUF_STRIDE),
    parameter int                ADDR_INC   = 4,
    parameter int                ROWS       = DEF_ROWS,
    parameter int                EXP_ROW    = DEF_ROWS,
    parameter int                NUM_EXP    = 3
) (
    input  logic              p_clk,
    input  logic              rst_n,
    input  logic [7:0]        data,
    input  logic              href,
    input  logic              vsync,
    input  logic              take_pic,
    input  logic              hdr_en,
    output logic [DATA_W-1:0] p_data,
    output logic [ADDR_W-1:0] wr_address,
    output logic              data_valid,
    input  logic              data_ready,
    output logic [2:0]        last_frame,
    output logic              frame_done,
    output logic              frame_err,
    output logic              change_exp,
    output logic [2:0]        exp_idx
);

    cap_state_t        state_q, state_d;
    logic              vsync_q, href_q;
    logic [ADDR_W-1:0] word_idx_q, word_idx_eff, buf_base;
    logic [ROW_W-1:0]  row_q, row_next;
    logic              ovf_q, exp_fired_q;
    logic [DATA_W-1:0] packed_word;
    logic              byte_en, packer_clear, word_done;
    logic              accept, drop, load;
    logic              vsync_rise, href_fall, row_inc, eval, commit, fire;

    assign vsync_rise   = vsync && !vsync_q;
    assign href_fall    = href_q && !href;
    assign byte_en      = (state_q == ST_CAPTURE) && href && !vsync;
    assign packer_clear = take_pic || (state_q != ST_CAPTURE);

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .p_clk     (p_clk),
        .rst_n     (rst_n),
        .clear     (packer_clear),
        .byte_en   (byte_en),
        .data      (data),
        .word      (packed_word),
        .word_done (word_done)
    );

    // A word completing while the held one stays unaccepted is lost.
    assign accept = data_valid && data_ready;
    assign drop   = word_done && data_valid && !data_ready;
    assign load   = word_done && !drop;

    assign word_idx_eff = word_idx_q + ADDR_W'(accept);
    assign buf_base     = ADDR_W'(last_frame) * BUF_STRIDE;

    assign row_inc  = (state_q == ST_CAPTURE) && href_fall;
    assign row_next = (row_inc && row_q != ROW_MAX) ? row_q + ROW_W'(1) : row_q;
    assign fire     = row_inc && hdr_en && !exp_fired_q && (row_next == ROW_W'(EXP_ROW));

    assign eval   = (state_q == ST_CAPTURE) && vsync_rise;
    assign commit = eval && (row_next == ROW_W'(ROWS)) && !(ovf_q || drop);

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_SYNC;
        else        state_q <= state_d;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (take_pic) begin
            state_d = ST_SYNC;
        end else begin
            case (state_q)
                ST_SYNC:    if (vsync)      state_d = ST_ARMED;
                ST_ARMED:   if (!vsync)     state_d = ST_CAPTURE;
                ST_CAPTURE: if (vsync_rise) state_d = ST_ARMED;
                default:                    state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            word_idx_q  <= '0;
            row_q       <= '0;
            ovf_q       <= 1'b0;
            exp_fired_q <= 1'b0;
            p_data      <= '0;
            wr_address  <= '0;
            data_valid  <= 1'b0;
            last_frame  <= '0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            change_exp  <= 1'b0;
            exp_idx     <= '0;
        end else if (take_pic) begin
            // Restart keeps the ring position and exposure slot.
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            word_idx_q  <= '0;
            row_q       <= '0;
            ovf_q       <= 1'b0;
            exp_fired_q <= 1'b0;
            p_data      <= '0;
            wr_address  <= '0;
            data_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            change_exp  <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            href_q     <= href;
            frame_done <= commit;
            frame_err  <= eval && !commit;
            change_exp <= fire;

            if (state_q == ST_ARMED) begin
                word_idx_q  <= '0;
                row_q       <= '0;
                ovf_q       <= 1'b0;
                exp_fired_q <= 1'b0;
            end else begin
                if (accept) word_idx_q  <= word_idx_q + ADDR_W'(1);
                if (row_inc) row_q      <= row_next;
                if (drop)   ovf_q       <= 1'b1;
                if (fire)   exp_fired_q <= 1'b1;
            end

            if (load) begin
                p_data     <= packed_word;
                wr_address <= buf_base + word_idx_eff * ADDR_W'(ADDR_INC);
                data_valid <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
            end

            if (commit)
                last_frame <= (last_frame == 3'(NUM_BUFS - 1)) ? 3'd0 : last_frame + 3'd1;

            if (!hdr_en)
                exp_idx <= '0;
            else if (commit)
                exp_idx <= (exp_idx == 3'(NUM_EXP - 1)) ? 3'd0 : exp_idx + 3'd1;
        end
    end

endmodule

// File: tb/tb_frame_capture_ring.sv
// Directed bench for frame_capture_ring with a transaction-level model
// checked every cycle plus hand-computed expectations per scenario.
module tb_frame_capture_ring;

    localparam int                DATA_W     = 32;
    localparam int                ADDR_W     = 25;
    localparam int                NUM_BUFS   = 3;
    localparam logic [ADDR_W-1:0] BUF_STRIDE = 25'h100;
    localparam int                ADDR_INC   = 4;
    localparam int                ROWS       = 2;
    localparam int                EXP_ROW    = 1;
    localparam int                NUM_EXP    = 3;

    logic              p_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        data = 8'h00;
    logic              href = 1'b0, vsync = 1'b0, take_pic = 1'b0, hdr_en = 1'b0;
    logic              data_ready = 1'b1;
    logic [DATA_W-1:0] p_data;
    logic [ADDR_W-1:0] wr_address;
    logic              data_valid, frame_done, frame_err, change_exp;
    logic [2:0]        last_frame, exp_idx;

    always #5 p_clk = ~p_clk;

    frame_capture_ring #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_BUFS(NUM_BUFS), .BUF_STRIDE(BUF_STRIDE),
        .ADDR_INC(ADDR_INC), .ROWS(ROWS), .EXP_ROW(EXP_ROW), .NUM_EXP(NUM_EXP)
    ) dut (
        .p_clk(p_clk), .rst_n(rst_n), .data(data), .href(href), .vsync(vsync),
        .take_pic(take_pic), .hdr_en(hdr_en), .p_data(p_data), .wr_address(wr_address),
        .data_valid(data_valid), .data_ready(data_ready), .last_frame(last_frame),
        .frame_done(frame_done), .frame_err(frame_err), .change_exp(change_exp),
        .exp_idx(exp_idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               m_blank, m_frame, m_pending, m_ovf, m_fired;
    bit               e_done, e_err, e_chg, m_vs_prev, m_href_prev;
    logic [7:0]       m_bytes[$];
    int               m_rows, m_widx, m_last, m_exp;
    logic [31:0]      m_word;
    logic [ADDR_W-1:0] m_addr;

    task automatic model_clear(input bit full);
        m_blank = 0; m_frame = 0; m_pending = 0; m_ovf = 0; m_fired = 0;
        e_done = 0; e_err = 0; e_chg = 0; m_vs_prev = 0; m_href_prev = 0;
        m_bytes.delete(); m_rows = 0; m_widx = 0;
        if (full) begin
            m_last = 0; m_exp = 0; m_word = '0; m_addr = '0;
        end
    endtask

    task automatic model_step();
        bit accept, new_word, href_fall;
        int rows_eval;
        if (!rst_n) begin
            model_clear(1'b1);
        end else if (take_pic) begin
            model_clear(1'b0);
        end else begin
            accept    = m_pending && data_ready;
            new_word  = 0;
            href_fall = m_href_prev && !href;
            e_done = 0; e_err = 0; e_chg = 0;
            if (!m_frame) begin
                if (!m_blank) m_blank = vsync;
                else if (!vsync) begin
                    m_frame = 1; m_widx = 0; m_rows = 0; m_ovf = 0; m_fired = 0;
                    m_bytes.delete();
                end
            end else if (vsync && !m_vs_prev) begin
                rows_eval = m_rows + (href_fall ? 1 : 0);
                if (rows_eval > 1023) rows_eval = 1023;
                if (rows_eval == ROWS && !m_ovf) begin
                    e_done = 1;
                    m_last = (m_last + 1) % NUM_BUFS;
                    if (hdr_en) m_exp = (m_exp + 1) % NUM_EXP;
                end else begin
                    e_err = 1;
                end
                m_frame = 0;
                m_bytes.delete();
            end else begin
                if (href && !vsync) begin
                    m_bytes.push_back(data);
                    if (m_bytes.size() == DATA_W / 8) begin
                        if (m_pending && !accept) m_ovf = 1;
                        else begin
                            new_word = 1;
                            m_word   = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                            m_addr   = ADDR_W'(m_last * int'(BUF_STRIDE)
                                               + (m_widx + (accept ? 1 : 0)) * ADDR_INC);
                        end
                        m_bytes.delete();
                    end
                end
                if (href_fall) begin
                    if (m_rows < 1023) m_rows++;
                    if (hdr_en && !m_fired && m_rows == EXP_ROW) begin
                        e_chg = 1; m_fired = 1;
                    end
                end
                if (accept) m_widx++;
            end
            if (new_word) m_pending = 1;
            else if (accept) m_pending = 0;
            if (!hdr_en) m_exp = 0;
            m_vs_prev   = vsync;
            m_href_prev = href;
        end
    endtask

    always @(posedge p_clk or negedge rst_n) model_step();

    // ---------------- per-cycle comparison ----------------
    logic [31:0]       acc_data[$];
    logic [ADDR_W-1:0] acc_addr[$];
    int done_cnt = 0, err_cnt = 0, chg_cnt = 0;

    task automatic compare_step();
        check("data_valid", 64'(data_valid), 64'(m_pending));
        if (m_pending) begin
            check("p_data", 64'(p_data), 64'(m_word));
            check("wr_address", 64'(wr_address), 64'(m_addr));
        end
        check("frame_done", 64'(frame_done), 64'(e_done));
        check("frame_err", 64'(frame_err), 64'(e_err));
        check("change_exp", 64'(change_exp), 64'(e_chg));
        check("last_frame", 64'(last_frame), 64'(m_last));
        check("exp_idx", 64'(exp_idx), 64'(m_exp));
        if (data_valid && data_ready) begin
            acc_data.push_back(p_data);
            acc_addr.push_back(wr_address);
        end
        if (frame_done) done_cnt++;
        if (frame_err)  err_cnt++;
        if (change_exp) chg_cnt++;
    endtask

    always @(negedge p_clk) if (rst_n) compare_step();

    // ---------------- stimulus ----------------
    task automatic tick(input logic v, input logic h, input logic [7:0] d);
        @(posedge p_clk);
        #2;
        vsync = v; href = h; data = d;
    endtask

    task automatic idle(input int n, input logic v);
        for (int i = 0; i < n; i++) tick(v, 1'b0, 8'h00);
    endtask

    task automatic send_row(input logic [7:0] first);
        for (int b = 0; b < 8; b++) tick(1'b0, 1'b1, first + 8'(b));
        idle(3, 1'b0);
    endtask

    task automatic send_frame(input int rows, input logic [7:0] first);
        idle(3, 1'b1);
        idle(2, 1'b0);
        for (int r = 0; r < rows; r++) send_row(first + 8'(r * 8));
        idle(4, 1'b1);
    endtask

    task automatic clear_log();
        acc_data.delete();
        acc_addr.delete();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge p_clk);
        #1;
        check("rst_data_valid", 64'(data_valid), 64'd0);
        check("rst_p_data", 64'(p_data), 64'd0);
        check("rst_wr_address", 64'(wr_address), 64'd0);
        check("rst_last_frame", 64'(last_frame), 64'd0);
        check("rst_exp_idx", 64'(exp_idx), 64'd0);
        check("rst_pulses", 64'({frame_done, frame_err, change_exp}), 64'd0);
        #1 rst_n = 1'b1;

        // Normal frame
        clear_log();
        send_frame(2, 8'h01);
        check("norm_count", 64'(acc_data.size()), 64'd4);
        check("norm_word0", 64'(acc_data[0]), 64'h04030201);
        check("norm_word3", 64'(acc_data[3]), 64'h100F0E0D);
        check("norm_addr0", 64'(acc_addr[0]), 64'h000);
        check("norm_addr1", 64'(acc_addr[1]), 64'h004);
        check("norm_addr2", 64'(acc_addr[2]), 64'h008);
        check("norm_addr3", 64'(acc_addr[3]), 64'h00C);
        check("norm_done", 64'(done_cnt), 64'd1);
        check("norm_last", 64'(last_frame), 64'd1);

        // Ring wrap
        clear_log();
        send_frame(2, 8'h11);
        send_frame(2, 8'h21);
        check("wrap_addr_b1", 64'(acc_addr[0]), 64'h100);
        check("wrap_addr_b2", 64'(acc_addr[4]), 64'h200);
        check("wrap_word_b2", 64'(acc_data[4]), 64'h24232221);
        check("wrap_last", 64'(last_frame), 64'd0);
        check("wrap_done", 64'(done_cnt), 64'd3);

        // Short frame, then the same buffer is reused
        clear_log();
        send_frame(1, 8'h31);
        check("short_err", 64'(err_cnt), 64'd1);
        check("short_no_done", 64'(done_cnt), 64'd3);
        check("short_last", 64'(last_frame), 64'd0);
        check("short_addr", 64'(acc_addr[0]), 64'h000);
        clear_log();
        send_frame(2, 8'h41);
        check("reuse_addr", 64'(acc_addr[0]), 64'h000);
        check("reuse_last", 64'(last_frame), 64'd1);

        // Backpressure over two word completions
        clear_log();
        data_ready = 1'b0;
        idle(3, 1'b1);
        idle(2, 1'b0);
        for (int b = 0; b < 8; b++) tick(1'b0, 1'b1, 8'h51 + 8'(b));
        tick(1'b0, 1'b0, 8'h00);
        check("bp_held_valid", 64'(data_valid), 64'd1);
        check("bp_held_data", 64'(p_data), 64'h54535251);
        check("bp_held_addr", 64'(wr_address), 64'h100);
        data_ready = 1'b1;
        idle(2, 1'b0);
        send_row(8'h59);
        idle(4, 1'b1);
        check("bp_count", 64'(acc_data.size()), 64'd3);
        check("bp_word1", 64'(acc_data[1]), 64'h5C5B5A59);
        check("bp_addr1", 64'(acc_addr[1]), 64'h104);
        check("bp_err", 64'(err_cnt), 64'd2);
        check("bp_last", 64'(last_frame), 64'd1);

        // HDR bracket
        hdr_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("hdr_exp_seq", 64'(exp_idx), 64'(k % 3));
            send_frame(2, 8'h61 + 8'(k * 16));
        end
        check("hdr_chg_cnt", 64'(chg_cnt), 64'd4);
        check("hdr_exp_end", 64'(exp_idx), 64'd1);
        check("hdr_last", 64'(last_frame), 64'd2);

        // Reset mid-frame
        clear_log();
        idle(3, 1'b1);
        idle(2, 1'b0);
        data_ready = 1'b0;
        for (int b = 0; b < 5; b++) tick(1'b0, 1'b1, 8'h81 + 8'(b));
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(data_valid), 64'd0);
        check("rst_mid_last", 64'(last_frame), 64'd0);
        check("rst_mid_exp", 64'(exp_idx), 64'd0);
        check("rst_mid_addr", 64'(wr_address), 64'd0);
        @(posedge p_clk);
        #2;
        rst_n = 1'b1;
        data_ready = 1'b1;
        for (int b = 0; b < 3; b++) tick(1'b0, 1'b1, 8'h86 + 8'(b));
        idle(3, 1'b0);
        send_row(8'h89);
        idle(4, 1'b1);
        check("rst_discard_words", 64'(acc_data.size()), 64'd0);
        check("rst_discard_done", 64'(done_cnt), 64'd8);
        check("rst_discard_err", 64'(err_cnt), 64'd2);
        send_frame(2, 8'h91);
        check("rst_next_addr", 64'(acc_addr[0]), 64'h000);
        check("rst_next_last", 64'(last_frame), 64'd1);
        check("rst_next_exp", 64'(exp_idx), 64'd1);

        // take_pic mid-frame
        clear_log();
        idle(3, 1'b1);
        idle(2, 1'b0);
        data_ready = 1'b0;
        for (int b = 0; b < 7; b++) tick(1'b0, 1'b1, 8'hA1 + 8'(b));
        check("tp_pre_valid", 64'(data_valid), 64'd1);
        take_pic = 1'b1;
        tick(1'b0, 1'b1, 8'hA8);
        take_pic = 1'b0;
        check("tp_valid", 64'(data_valid), 64'd0);
        check("tp_last_kept", 64'(last_frame), 64'd1);
        check("tp_exp_kept", 64'(exp_idx), 64'd1);
        data_ready = 1'b1;
        idle(3, 1'b0);
        send_row(8'hA9);
        idle(4, 1'b1);
        check("tp_discard_done", 64'(done_cnt), 64'd9);
        check("tp_discard_err", 64'(err_cnt), 64'd2);
        clear_log();
        send_frame(2, 8'hB1);
        check("tp_next_addr", 64'(acc_addr[0]), 64'h100);
        check("tp_next_word", 64'(acc_data[0]), 64'hB4B3B2B1);
        check("tp_next_last", 64'(last_frame), 64'd2);
        check("tp_next_exp", 64'(exp_idx), 64'd2);

        idle(3, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_capture_ring.md
# frame_capture_ring

Parametrised camera capture front-end. It packs the 8-bit parallel pixel stream into `DATA_W`-bit words and writes them into a ring of `NUM_BUFS` frame buffers in DDR. It rejects short or overflowed frames instead of committing them, and drives a configurable exposure bracket for HDR. It sits between the camera pins (pclk domain) and the DDR write arbiter, and succeeds the fixed 128-bit, 6-buffer capture block.

## Interface
- `DATA_W`, default 128: output word width; multiple of 8, minimum 16. `BPW = DATA_W/8` bytes per word.
- `ADDR_W`, default 25: DDR address width.
- `NUM_BUFS`, default 6: frame buffers in ring, 2..8.
- `BUF_STRIDE`, default 25'h25800: address distance between buffer bases; buffer `n` base = `n*BUF_STRIDE`.
- `ADDR_INC`, default 4: address increment per word.
- `ROWS`, default 480: rows required for a valid frame.
- `EXP_ROW`, default 480: row count at which the exposure change fires, 1..`ROWS`.
- `NUM_EXP`, default 3: exposures in HDR bracket, 1..8.
- `p_clk` in 1: pixel clock, sole clock.
- `rst_n` in 1: asynchronous active-low reset.
- `data` in 8: camera pixel byte.
- `href` in 1: line valid, high during active bytes.
- `vsync` in 1: high = vertical blanking; frame runs while low.
- `take_pic` in 1: synchronous soft restart.
- `hdr_en` in 1: enable exposure bracketing.
- `p_data` out `DATA_W`: packed word.
- `wr_address` out `ADDR_W`: DDR address of `p_data`.
- `data_valid` out 1: word valid.
- `data_ready` in 1: consumer accepts the word.
- `last_frame` out 3: index of the buffer being written.
- `frame_done` out 1: one-cycle pulse; frame committed.
- `frame_err` out 1: one-cycle pulse; frame rejected.
- `change_exp` out 1: one-cycle pulse; sensor exposure must change.
- `exp_idx` out 3: exposure index for the frame being captured.

## Operation
- **Reset values.** All outputs are 0. The FSM is in SYNC. The byte, word and row counters are 0.
- **take_pic.** Same clearing as reset, except `last_frame` and `exp_idx` are retained. `take_pic` has priority over all other activity.
- **FSM states.**
  - SYNC: waits for `vsync`=1, then goes to ARMED. This discards any frame already in progress when the block comes out of reset or restart.
  - ARMED: on `vsync`=0, goes to CAPTURE. Clears the word index, row count and overflow flag.
  - CAPTURE: on a `vsync` rising edge (`vsync`=1, previous sample 0), evaluates the frame and returns to ARMED.
- **Packing.** In CAPTURE with `href`=1, each byte goes to lane `k` (the byte count within the word). The first byte lands in `p_data[7:0]`; byte `k` lands in `[8k+7:8k]`.
  - After byte `BPW-1`, the word is complete and the byte count wraps to 0.
- **Partial words.** Byte count is not reset on `href` falling; words span row boundaries. A partial word at frame end is discarded and the byte count cleared; the frame is still evaluated normally.
- **Word output.** On word completion, `wr_address = last_frame*BUF_STRIDE + word_idx*ADDR_INC` and `data_valid` is set. `word_idx` increments only on accepted words.
  - `data_valid` holds with `p_data` and `wr_address` stable until `data_valid && data_ready`.
- **Overflow.** If a word completes while the held word is not accepted in that cycle, the new word is dropped and the frame overflow flag is set.
- **Row count.** Increments on each `href` falling edge; saturates at 1023.
- **Frame evaluation.**
  - If rows == `ROWS` and no overflow: `frame_done` pulses and `last_frame` advances, wrapping from `NUM_BUFS-1` to 0.
  - Otherwise: `frame_err` pulses and `last_frame` is unchanged, so the same buffer is overwritten.
- **Exposure, `hdr_en`=1.** When the row count first equals `EXP_ROW` in a frame, `change_exp` pulses once. On a committed frame, `exp_idx` advances modulo `NUM_EXP`; a rejected frame keeps `exp_idx`.
- **Exposure, `hdr_en`=0.** `exp_idx` is forced to 0 and there are no `change_exp` pulses.

## Timing
- Pixel inputs are sampled on the `p_clk` rising edge.
- `data_valid` rises 1 cycle after the edge sampling the last byte of a word.
- With `data_ready` tied high, throughput is 1 word per `BPW` cycles and no overflow can occur for `BPW` ≥ 2.
- `frame_done` / `frame_err` assert 1 cycle after the edge that samples the `vsync` rise. `last_frame` and `exp_idx` update on that same edge, so they are new while the pulse is high.
- `change_exp` asserts 1 cycle after the edge where the row count reaches `EXP_ROW`.
- A held output word pending at frame end remains valid until accepted, and keeps its old-buffer address.

## Structure
- Shared package `capture_pkg`: FSM state encoding (SYNC, ARMED, CAPTURE) and the default geometry constants (640x480 stride, 480 rows).
- One sub-module, `byte_packer`, is natural. It is parametrised by `DATA_W`, contains the lane counter and lane write, and emits a word-complete strobe.
- FSM, address generation, output handshake and exposure logic stay in the top module.

## Test plan
Bench parameters: `DATA_W`=32, `ROWS`=2, `EXP_ROW`=1, `NUM_BUFS`=3, `BUF_STRIDE`=0x100.
- **Normal frame.** One frame of 2 rows × 8 bytes (0x01..0x10), `data_ready`=1 → 4 words, first `p_data`=0x04030201 at address 0x000, then addresses 0x004/0x008/0x00C; `frame_done` pulses; `last_frame`=1.
- **Ring wrap.** Three good frames → writes to bases 0x000, 0x100, 0x200; `last_frame` returns to 0.
- **Short frame.** 1 row then `vsync` rises → `frame_err` pulse; no `frame_done`; `last_frame` unchanged; next frame writes the same base.
- **Backpressure.** `data_ready`=0 over two word completions → first word held stable, second dropped, `frame_err` at frame end.
- **HDR.** `hdr_en`=1, `NUM_EXP`=3, four good frames → `change_exp` pulses once per frame after row 1; `exp_idx` sequence 0,1,2,0.
- **Restart.** Reset asserted mid-frame → all outputs 0 immediately; after release, capture waits for a `vsync` high/low cycle. `take_pic` mid-frame → same, with `last_frame` kept.
